// File: rtl/opacc_seq.sv
// Command sequencer and initiator for the outer-product accumulator array.
// Define OPACC_SEQ_PERF_EN to add saturating performance counters.
module opacc_seq #(
  parameter int nregs  = 2,
  parameter int ml     = 4,
  parameter int vl     = 4,
  parameter int XLEN   = 64,
  parameter int ST_LAT = 1,
  parameter int LENW   = 16,
  localparam int AW    = (nregs > 1) ? $clog2(nregs) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [AW-1:0]      cmd_addr,
  input  logic [LENW-1:0]    cmd_len,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [ml*XLEN-1:0] op_a,
  input  logic [vl*XLEN-1:0] op_b,
  input  logic               cin_valid,
  output logic               cin_ready,
  input  logic [vl*XLEN-1:0] cin_data,
  output logic               cout_valid,
  input  logic               cout_ready,
  output logic [vl*XLEN-1:0] cout_data,
  output logic               ab_valid,
  output logic               ci_valid,
  output logic               co_valid,
  output logic [ml*XLEN-1:0] ai,
  output logic [vl*XLEN-1:0] bi,
  output logic [vl*XLEN-1:0] ci,
  input  logic [vl*XLEN-1:0] co,
  output logic [AW-1:0]      cld_addr,
  output logic [AW-1:0]      cst_addr,
  output logic [AW-1:0]      ab_addr,
  output logic               done,
  output logic               busy
`ifdef OPACC_SEQ_PERF_EN
  ,
  input  logic               perf_clr,
  output logic [31:0]        perf_mac_beats,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_busy_cycles
`endif
);

  localparam int DEPTH = ST_LAT + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam logic [PW:0]     OCC_ONE  = (PW+1)'(1);
  localparam logic [PW:0]     OCC_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
  localparam logic [LENW-1:0] CNT_ONE  = LENW'(1);
  localparam logic [LENW-1:0] CNT_ML   = LENW'(ml);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_STORE, S_ZERO, S_DRAIN} state_t;

  state_t              r_state;
  logic [AW-1:0]       r_addr;
  logic [LENW-1:0]     r_cnt;
  logic                r_done;
  logic [ST_LAT-1:0]   r_vld_p;
  logic [vl*XLEN-1:0]  r_mem [DEPTH];
  logic [PW-1:0]       r_wp, r_rp;
  logic [PW:0]         r_occ, r_outst;

  logic w_cin_hs, w_op_hs, w_zero, w_issue, w_beat, w_push, w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign w_cin_hs = (r_state == S_LOAD) && cin_valid;
  assign w_op_hs  = (r_state == S_MAC) && op_valid;
  assign w_zero   = (r_state == S_ZERO);
  // Credit covers rows still in the latency pipe plus rows waiting in the FIFO.
  assign w_issue  = (r_state == S_STORE) && (r_outst < OCC_FULL);
  assign w_beat   = w_cin_hs || w_op_hs || w_zero || w_issue;
  assign w_push   = r_vld_p[ST_LAT-1];
  assign w_pop    = cout_valid && cout_ready;

  assign cmd_ready = reset && (r_state == S_IDLE);
  assign cin_ready = (r_state == S_LOAD);
  assign op_ready  = (r_state == S_MAC);
  assign ci_valid  = w_cin_hs || w_zero;
  assign ci        = w_cin_hs ? cin_data : '0;
  assign cld_addr  = ci_valid ? r_addr : '0;
  assign ab_valid  = w_op_hs;
  assign ai        = w_op_hs ? op_a : '0;
  assign bi        = w_op_hs ? op_b : '0;
  assign ab_addr   = w_op_hs ? r_addr : '0;
  assign co_valid  = w_issue;
  assign cst_addr  = w_issue ? r_addr : '0;
  assign cout_valid = (r_occ != '0);
  assign cout_data  = cout_valid ? r_mem[r_rp] : '0;
  assign done = r_done;
  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_addr <= cmd_addr;
          r_cnt  <= CNT_ML;
          case (cmd_op)
            2'd0: r_state <= S_LOAD;
            2'd1: if (cmd_len == '0) r_done <= 1'b1;
                  else begin
                    r_state <= S_MAC;
                    r_cnt   <= cmd_len;
                  end
            2'd2: r_state <= S_STORE;
            default: r_state <= S_ZERO;
          endcase
        end
        S_LOAD, S_MAC, S_ZERO, S_STORE: if (w_beat) begin
          if (r_cnt == CNT_ONE) begin
            if (r_state == S_STORE) r_state <= S_DRAIN;
            else begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_DRAIN: if (r_outst == '0) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Store return path: issue -> ST_LAT valid stages -> FIFO push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_p <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_occ   <= '0;
      r_outst <= '0;
    end else begin
      r_vld_p[0] <= w_issue;
      for (int i = 1; i < ST_LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
      if (w_push) r_wp <= ptr_inc(r_wp);
      if (w_pop)  r_rp <= ptr_inc(r_rp);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
      case ({w_issue, w_pop})
        2'b10:   r_outst <= r_outst + OCC_ONE;
        2'b01:   r_outst <= r_outst - OCC_ONE;
        default: r_outst <= r_outst;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= co;
  end

`ifdef OPACC_SEQ_PERF_EN
  logic [31:0] r_perf_mac, r_perf_stall, r_perf_busy;
  logic        w_stall;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  assign w_stall = ((r_state == S_LOAD) || (r_state == S_MAC) || (r_state == S_STORE) ||
                    (r_state == S_DRAIN)) && !(ab_valid || ci_valid || co_valid) && !w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_mac   <= '0;
      r_perf_stall <= '0;
      r_perf_busy  <= '0;
    end else if (perf_clr) begin
      r_perf_mac   <= '0;
      r_perf_stall <= '0;
      r_perf_busy  <= '0;
    end else begin
      r_perf_mac   <= sat_inc(r_perf_mac, ab_valid);
      r_perf_stall <= sat_inc(r_perf_stall, w_stall);
      r_perf_busy  <= sat_inc(r_perf_busy, busy);
    end
  end

  assign perf_mac_beats    = r_perf_mac;
  assign perf_stall_cycles = r_perf_stall;
  assign perf_busy_cycles  = r_perf_busy;
`endif

endmodule

// File: tb/tb_opacc_seq.sv
// Scoreboard bench for opacc_seq: random streams, a fake delayed-readback array,
// and an intent-level model of C register contents.
module tb_opacc_seq;
  localparam int NREGS  = 2;
  localparam int ML     = 4;
  localparam int VL     = 4;
  localparam int XLEN   = 64;
  localparam int ST_LAT = 2;
  localparam int LENW   = 8;
  localparam int AW     = 1;
  localparam int ROW    = VL * XLEN;
  localparam int AROW   = ML * XLEN;
  localparam logic [1:0] OP_LOAD = 2'd0, OP_MAC = 2'd1, OP_STORE = 2'd2, OP_ZERO = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [LENW-1:0] cmd_len;
  logic op_valid, op_ready;
  logic [AROW-1:0] op_a;
  logic [ROW-1:0] op_b;
  logic cin_valid, cin_ready;
  logic [ROW-1:0] cin_data;
  logic cout_valid, cout_ready;
  logic [ROW-1:0] cout_data;
  logic ab_valid, ci_valid, co_valid;
  logic [AROW-1:0] ai;
  logic [ROW-1:0] bi, ci, co;
  logic [AW-1:0] cld_addr, cst_addr, ab_addr;
  logic done, busy;
`ifdef OPACC_SEQ_PERF_EN
  logic perf_clr;
  logic [31:0] perf_mac_beats, perf_stall_cycles, perf_busy_cycles;
`endif

  opacc_seq #(.nregs(NREGS), .ml(ML), .vl(VL), .XLEN(XLEN), .ST_LAT(ST_LAT), .LENW(LENW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .cin_valid(cin_valid), .cin_ready(cin_ready), .cin_data(cin_data),
    .cout_valid(cout_valid), .cout_ready(cout_ready), .cout_data(cout_data),
    .ab_valid(ab_valid), .ci_valid(ci_valid), .co_valid(co_valid),
    .ai(ai), .bi(bi), .ci(ci), .co(co),
    .cld_addr(cld_addr), .cst_addr(cst_addr), .ab_addr(ab_addr),
    .done(done), .busy(busy)
`ifdef OPACC_SEQ_PERF_EN
    , .perf_clr(perf_clr), .perf_mac_beats(perf_mac_beats),
    .perf_stall_cycles(perf_stall_cycles), .perf_busy_cycles(perf_busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int due; logic [ROW-1:0] row;} dly_t;
  dly_t dq[$];
  logic [ROW-1:0] exp_cout[$];
  logic [ROW-1:0] ref_mem [NREGS][ML];
  logic [ROW-1:0] arr [NREGS][ML];
  logic [ROW-1:0] garb;

  int n_tests = 0, n_fail = 0;
  int n_ci, n_ab, n_co, n_done, n_bad, acc_cyc, last_cyc, done_cyc;
  logic [1:0] cur_op;
  logic [AW-1:0] cur_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [ROW-1:0] rnd_row();
    logic [ROW-1:0] r;
    for (int w = 0; w < ROW / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic outs_or();
    return |{cmd_ready, op_ready, cin_ready, cout_valid, cout_data, ab_valid, ci_valid, co_valid,
             ai, bi, ci, cld_addr, cst_addr, ab_addr, done, busy};
  endfunction

  // Monitor: plays the array (delayed C readback) and pops the cout scoreboard.
  task automatic monitor();
    logic [ROW-1:0] er;
    forever begin
      @(negedge clk);
      if (!reset) begin
        dq.delete();
        co = garb;
      end else begin
        if (cmd_valid && cmd_ready) begin
          cur_op = cmd_op; cur_addr = cmd_addr;
          n_ci = 0; n_ab = 0; n_co = 0; n_done = 0; n_bad = 0;
          acc_cyc = cyc; last_cyc = cyc; done_cyc = 0;
        end
        if (int'(ab_valid) + int'(ci_valid) + int'(co_valid) > 1) n_bad++;
        if (cin_ready && cur_op != OP_LOAD) n_bad++;
        if (op_ready && cur_op != OP_MAC) n_bad++;
        if (ci_valid) begin
          if (cld_addr !== cur_addr) n_bad++;
          if (cur_op == OP_ZERO && ci !== '0) n_bad++;
          if (cur_op == OP_LOAD && (!(cin_valid && cin_ready) || ci !== cin_data)) n_bad++;
          arr[cld_addr][n_ci % ML] = ci;
          n_ci++; last_cyc = cyc;
        end
        if (ab_valid) begin
          if (ab_addr !== cur_addr || !op_valid || ai !== op_a || bi !== op_b) n_bad++;
          n_ab++; last_cyc = cyc;
        end
        if (co_valid) begin
          if (cst_addr !== cur_addr) n_bad++;
          dq.push_back('{due: cyc + ST_LAT, row: arr[cst_addr][n_co % ML]});
          n_co++; last_cyc = cyc;
        end
        if (done) begin
          n_done++; done_cyc = cyc;
        end
        if (cout_valid && cout_ready) begin
          n_tests++;
          if (exp_cout.size() == 0) begin
            n_fail++;
            $display("FAIL cout_extra: got %h expected no row", cout_data);
          end else begin
            er = exp_cout.pop_front();
            if (cout_data !== er) begin
              n_fail++;
              $display("FAIL cout_row: got %h expected %h", cout_data, er);
            end
          end
        end
        if (dq.size() > 0 && dq[0].due == cyc) begin
          co = dq[0].row;
          void'(dq.pop_front());
        end else begin
          co = garb;
        end
      end
    end
  endtask

  // pat: 0 always valid, 1 every other cycle, 2 random, 3 two fixed bubbles.
  // rpat: 0 ready held high, 1 random ready, 2 ready low for 20 cycles then high.
  task automatic run_cmd(input logic [1:0] op, input int addr, input int len,
                         input int pat, input int rpat, input bit fixed_rows);
    logic [ROW-1:0] rows [ML];
    int idx, exp_n;
    bit acc, got, v;
    for (int i = 0; i < ML; i++) rows[i] = fixed_rows ? ROW'(i + 1) : rnd_row();
    case (op)
      OP_LOAD:  for (int i = 0; i < ML; i++) ref_mem[addr][i] = rows[i];
      OP_ZERO:  for (int i = 0; i < ML; i++) ref_mem[addr][i] = '0;
      OP_STORE: for (int i = 0; i < ML; i++) exp_cout.push_back(ref_mem[addr][i]);
      default:  ;
    endcase
    exp_n = (op == OP_MAC) ? len : ML;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = AW'(addr); cmd_len = LENW'(len);
    acc = 1'b0;
    for (int w = 0; w < 20 && !acc; w++) begin
      @(negedge clk);
      if (cmd_ready) acc = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("cmd_accept", 64'(acc), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom);
    idx = 0; got = 1'b0;
    for (int k = 0; k < 3000 && acc && !got; k++) begin
      case (pat)
        0: v = 1'b1;
        1: v = (k % 2 == 0);
        2: v = ($urandom_range(99) < 60);
        default: v = (k != 1 && k != 3);
      endcase
      cin_valid = v;
      cin_data = (idx < ML) ? rows[idx] : rnd_row();
      op_valid = v;
      op_a = AROW'(rnd_row());
      op_b = rnd_row();
      case (rpat)
        0: cout_ready = 1'b1;
        1: cout_ready = 1'($urandom_range(1));
        default: cout_ready = (k >= 20);
      endcase
      if (rpat == 2 && k == 20)
        chk("store_credit_stall", 64'(n_co), 64'((ST_LAT + 1 < ML) ? ST_LAT + 1 : ML));
      @(negedge clk);
      if (cin_valid && cin_ready) idx++;
      if (done) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    cin_valid = 1'b0; op_valid = 1'b0;
    chk("done_seen", 64'(got), 64'd1);
    if (got) begin
      chk("done_count", 64'(n_done), 64'd1);
      chk("ci_beats", 64'(n_ci), 64'((op == OP_LOAD || op == OP_ZERO) ? exp_n : 0));
      chk("ab_beats", 64'(n_ab), 64'((op == OP_MAC) ? exp_n : 0));
      chk("co_issues", 64'(n_co), 64'((op == OP_STORE) ? exp_n : 0));
      chk("protocol_errs", 64'(n_bad), 64'd0);
      if (op != OP_STORE) chk("done_timing", 64'(done_cyc), 64'(last_cyc + 1));
      if (op == OP_ZERO) chk("zero_consecutive", 64'(done_cyc - acc_cyc), 64'(ML + 1));
      if (op == OP_STORE) chk("cout_drained", 64'(exp_cout.size()), 64'd0);
    end
    exp_cout.delete();
  endtask

  task automatic reset_mid_store();
    int seen;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = OP_STORE; cmd_addr = AW'(1); cout_ready = 1'b0;
    @(negedge clk);
    chk("rst_pre_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    seen = 0;
    for (int w = 0; w < 20 && seen < 2; w++) begin
      @(negedge clk);
      if (co_valid) seen++;
    end
    chk("rst_two_issues", 64'(seen), 64'd2);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("rst_async_outputs_zero", 64'(outs_or()), 64'd0);
    @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_after_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_after_busy", 64'(busy), 64'd0);
    chk("rst_after_cout_valid", 64'(cout_valid), 64'd0);
    exp_cout.delete();
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0;
    cin_valid = 1'b0; cin_data = '0; cout_ready = 1'b0;
    garb = {(ROW / 16){16'hDEAD}};
    co = garb;
`ifdef OPACC_SEQ_PERF_EN
    perf_clr = 1'b0;
`endif
    for (int r = 0; r < NREGS; r++)
      for (int i = 0; i < ML; i++) begin
        ref_mem[r][i] = '0;
        arr[r][i] = '0;
      end
    n_ci = 0; n_ab = 0; n_co = 0; n_done = 0; n_bad = 0;
    acc_cyc = 0; last_cyc = 0; done_cyc = 0; cur_op = OP_LOAD; cur_addr = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero", 64'(outs_or()), 64'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_cout_valid", 64'(cout_valid), 64'd0);

    run_cmd(OP_LOAD, 1, 0, 0, 0, 1'b1);
    run_cmd(OP_STORE, 1, 0, 0, 0, 1'b0);
    run_cmd(OP_MAC, 0, 3, 1, 0, 1'b0);
    run_cmd(OP_MAC, 1, 0, 0, 0, 1'b0);
    run_cmd(OP_LOAD, 0, 0, 2, 0, 1'b0);
    run_cmd(OP_STORE, 0, 0, 0, 2, 1'b0);
    run_cmd(OP_ZERO, 0, 0, 0, 0, 1'b0);
    run_cmd(OP_STORE, 0, 0, 0, 1, 1'b0);
    for (int t = 0; t < 12; t++)
      run_cmd(2'($urandom_range(3)), $urandom_range(NREGS - 1), $urandom_range(9), 2, 1, 1'b0);
    run_cmd(OP_MAC, 1, (1 << LENW) - 1, 0, 0, 1'b0);

    reset_mid_store();
    run_cmd(OP_LOAD, 1, 0, 2, 0, 1'b0);
    run_cmd(OP_STORE, 1, 0, 0, 1, 1'b0);

`ifdef OPACC_SEQ_PERF_EN
    @(posedge clk); #1;
    perf_clr = 1'b1;
    @(posedge clk); #1;
    perf_clr = 1'b0;
    run_cmd(OP_MAC, 0, 5, 3, 0, 1'b0);
    chk("perf_mac_beats", 64'(perf_mac_beats), 64'd5);
    chk("perf_stall_cycles", 64'(perf_stall_cycles), 64'd2);
    perf_clr = 1'b1;
    @(posedge clk); #1;
    perf_clr = 1'b0;
    @(negedge clk);
    chk("perf_clr_zero", 64'(perf_mac_beats | perf_stall_cycles | perf_busy_cycles), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
